// File: rtl/seq_calculator_if.sv
// seq_calculator_if: request/response handshake bundle between the operand front end and seq_calculator.
interface seq_calculator_if #(
    parameter int NB = 48
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [NB-1:0] a;
    logic signed [NB-1:0] b;
    logic signed [NB-1:0] result;
    logic [2:0]           op;
    logic [2:0]           status;
    modport master(output in_valid, a, b, op, out_ready, input in_ready, out_valid, result, status);
    modport slave(input in_valid, a, b, op, out_ready, output in_ready, out_valid, result, status);
endinterface

// File: rtl/seq_calculator.sv
// seq_calculator: handshaked signed decimal-range calculator (add/sub/mul, iterative div/pow).
// Define CALC_MOD_EN to enable op 5 (MOD) from the divider remainder.
module seq_calculator #(
    parameter int DIGITS = 12,
    parameter int NB     = 48
) (
    input logic             clk,
    input logic             rst_n,
    seq_calculator_if.slave bus
);
    localparam int W = 2 * NB;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3, OP_POW = 3'd4, OP_MOD = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_DIV0 = 3'd1, ST_NEG_EXP = 3'd2, ST_BAD_OP = 3'd3, ST_OVERFLOW = 3'd4, ST_IN_RANGE = 3'd5;

    function automatic logic [NB-1:0] calc_maxv();
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < DIGITS; i++) v = v * 64'd10;
        return NB'(v - 64'd1);
    endfunction

    localparam logic [NB-1:0]        MAXV = calc_maxv();
    localparam logic signed [W-1:0] WMAX = {{NB{1'b0}}, MAXV};

    function automatic logic too_big(input logic signed [W-1:0] w);
        return w > WMAX || w < -WMAX;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV, S_POW, S_DONE} state_t;

    state_t               state, n_state;
    logic signed [NB-1:0] ra, rb, n_ra, n_rb, acc, n_acc, res, n_res;
    logic [2:0]           rop, n_op, sts, n_sts;
    logic [NB-1:0]        quo, n_quo, cnt, n_cnt, ma, mb, t, qn;
    logic [NB-2:0]        rem, n_rem, rn;
    logic signed [W-1:0]  sa, sb, arith, prod;
    logic                 ge, is_div, bad_op;

`ifdef CALC_MOD_EN
    assign is_div = rop == OP_DIV || rop == OP_MOD;
    assign bad_op = rop > OP_MOD;
`else
    assign is_div = rop == OP_DIV;
    assign bad_op = rop >= OP_MOD;
`endif

    assign ma    = ra[NB-1] ? -ra : ra;
    assign mb    = rb[NB-1] ? -rb : rb;
    // Remainder always stays below |b| <= MAXV, so one bit narrower than the operands suffices.
    assign t     = {rem, quo[NB-1]};
    assign ge    = t >= mb;
    assign rn    = ge ? (NB-1)'(t - mb) : t[NB-2:0];
    assign qn    = {quo[NB-2:0], ge};
    assign sa    = {{NB{ra[NB-1]}}, ra};
    assign sb    = {{NB{rb[NB-1]}}, rb};
    assign arith = rop == OP_ADD ? sa + sb : rop == OP_SUB ? sa - sb : rop == OP_MUL ? sa * sb : W'(1);
    assign prod  = {{NB{acc[NB-1]}}, acc} * sa;

    assign bus.in_ready  = state == S_IDLE;
    assign bus.out_valid = state == S_DONE;
    assign bus.result    = res;
    assign bus.status    = sts;

    always_comb begin
        n_state = state;
        n_ra    = ra;
        n_rb    = rb;
        n_op    = rop;
        n_acc   = acc;
        n_res   = res;
        n_sts   = sts;
        n_quo   = quo;
        n_rem   = rem;
        n_cnt   = cnt;
        case (state)
            S_IDLE: if (bus.in_valid) begin
                n_state = S_CHECK;
                n_ra    = bus.a;
                n_rb    = bus.b;
                n_op    = bus.op;
            end
            S_CHECK: begin
                n_state = S_DONE;
                n_res   = '0;
                if (bad_op) n_sts = ST_BAD_OP;
                else if (ma > MAXV || mb > MAXV) n_sts = ST_IN_RANGE;
                else if (is_div && rb == '0) n_sts = ST_DIV0;
                else if (rop == OP_POW && rb[NB-1]) n_sts = ST_NEG_EXP;
                else if (is_div) begin
                    n_state = S_DIV;
                    n_quo   = ma;
                    n_rem   = '0;
                    n_cnt   = NB'(NB);
                end else if (rop == OP_POW && rb != '0) begin
                    n_state = S_POW;
                    n_acc   = NB'(1);
                    n_cnt   = rb;
                end else begin
                    n_sts = too_big(arith) ? ST_OVERFLOW : ST_OK;
                    n_res = too_big(arith) ? '0 : arith[NB-1:0];
                end
            end
            S_DIV: begin
                n_quo = qn;
                n_rem = rn;
                n_cnt = cnt - 1'b1;
                if (cnt == NB'(1)) begin
                    n_state = S_DONE;
                    n_sts   = ST_OK;
                    n_res   = rop == OP_DIV ? (ra[NB-1] ^ rb[NB-1] ? -qn : qn) : (ra[NB-1] ? -{1'b0, rn} : {1'b0, rn});
                end
            end
            S_POW: begin
                n_cnt = cnt - 1'b1;
                n_acc = prod[NB-1:0];
                if (too_big(prod)) begin
                    n_state = S_DONE;
                    n_sts   = ST_OVERFLOW;
                    n_res   = '0;
                end else if (cnt == NB'(1)) begin
                    n_state = S_DONE;
                    n_sts   = ST_OK;
                    n_res   = prod[NB-1:0];
                end
            end
            S_DONE: if (bus.out_ready) n_state = S_IDLE;
            default: n_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ra    <= '0;
            rb    <= '0;
            rop   <= '0;
            acc   <= '0;
            res   <= '0;
            sts   <= '0;
            quo   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else begin
            state <= n_state;
            ra    <= n_ra;
            rb    <= n_rb;
            rop   <= n_op;
            acc   <= n_acc;
            res   <= n_res;
            sts   <= n_sts;
            quo   <= n_quo;
            rem   <= n_rem;
            cnt   <= n_cnt;
        end
    end
endmodule

// File: tb/tb_seq_calculator.sv
// tb_seq_calculator: randomized scoreboard bench for seq_calculator against a wide-integer arithmetic model.
module tb_seq_calculator;
    localparam int     NB   = 48;
    localparam longint MAXV = 64'sd999999999999;
`ifdef CALC_MOD_EN
    localparam bit MOD_EN = 1'b1;
`else
    localparam bit MOD_EN = 1'b0;
`endif

    typedef struct {
        longint res;
        int     sts;
        int     lat;
        int     t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   bp = 1'b0;
    bit   seen = 1'b0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_calculator_if #(.NB(NB)) bus();
    seq_calculator #(.DIGITS(12), .NB(NB)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b, input int op);
        exp_t e;
        logic signed [127:0] wa, wb, w, lim;
        bit ovf;
        wa = a;
        wb = b;
        lim = MAXV;
        w = 0;
        e.res = 0;
        e.sts = 0;
        e.lat = 2;
        e.t0 = 0;
        if (op > 5 || (op == 5 && !MOD_EN)) e.sts = 3;
        else if (wa > lim || wa < -lim || wb > lim || wb < -lim) e.sts = 5;
        else if ((op == 3 || op == 5) && b == 0) e.sts = 1;
        else if (op == 4 && b < 0) e.sts = 2;
        else begin
            if (op == 0) w = wa + wb;
            else if (op == 1) w = wa - wb;
            else if (op == 2) w = wa * wb;
            else if (op == 3) begin
                w = wa / wb;
                e.lat = NB + 2;
            end else if (op == 5) begin
                w = wa % wb;
                e.lat = NB + 2;
            end else begin
                w = 1;
                e.lat = int'(b) + 2;
                for (int i = 0; i < b; i++) begin
                    w = w * wa;
                    if (w > lim || w < -lim) begin
                        e.lat = i + 3;
                        break;
                    end
                end
            end
            ovf = w > lim || w < -lim;
            e.sts = ovf ? 4 : 0;
            e.res = ovf ? 0 : longint'(w);
        end
        return e;
    endfunction

    function automatic longint rnd_val();
        longint m;
        case ($urandom % 6)
            0: return longint'($urandom % 41) - 20;
            1: return MAXV - longint'($urandom % 3);
            2: return -MAXV + longint'($urandom % 3);
            3: begin
                m = longint'({$urandom, $urandom} & 64'h7fff_ffff_ffff_ffff) % (2 * MAXV + 1);
                return m - MAXV;
            end
            4: return ($urandom % 2) ? MAXV + 1 + longint'($urandom % 1000) : -MAXV - 1 - longint'($urandom % 1000);
            default: return longint'($urandom % 2000001) - 1000000;
        endcase
    endfunction

    // One cycle after acceptance the operands are scrambled while in_valid stays high; the DUT is busy and must ignore them.
    task automatic issue(input longint a, input longint b, input logic [2:0] op);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("issue_wait_ready", 0, 1);
            return;
        end
        bus.a = NB'(a);
        bus.b = NB'(b);
        bus.op = op;
        bus.in_valid = 1'b1;
        e = model(a, b, int'(op));
        e.t0 = cyc;
        q.push_back(e);
        @(negedge clk);
        bus.a = NB'({$urandom, $urandom});
        bus.b = NB'({$urandom, $urandom});
        bus.op = 3'($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", longint'(q.size()), 0);
            q.delete();
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp ? 1'b0 : ($urandom % 3 != 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) seen = 1'b0;
        else if (bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                chk("out_pending", longint'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    chk("latency", longint'(cyc - q[0].t0), longint'(q[0].lat));
                    chk("result_first", bus.result, q[0].res);
                end
            end
            if (bus.out_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("result", bus.result, e.res);
                    chk("status", longint'(bus.status), longint'(e.sts));
                end
                seen = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        longint a, b;
        int n;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_result", bus.result, 0);
        chk("rst_status", longint'(bus.status), 0);
        rst_n = 1'b1;

        issue(MAXV, 0, 3'd0);
        issue(MAXV, 1, 3'd0);
        issue(-7, 2, 3'd3);
        issue(5, 0, 3'd3);
        issue(10, 13, 3'd4);
        issue(2, -1, 3'd4);
        issue(-7, 2, 3'd5);
        issue(-7, 2, 3'd6);
        issue(3, 3, 3'd7);
        issue(999999, 1000001, 3'd2);
        issue(-MAXV, 1, 3'd1);
        issue(-MAXV, 0, 3'd1);
        issue(MAXV + 1, 0, 3'd0);
        issue(MAXV + 1, 0, 3'd6);
        issue(MAXV + 1, 0, 3'd3);
        issue(0, 0, 3'd4);
        issue(-3, 5, 3'd4);
        issue(MAXV, -1, 3'd3);
        issue(-MAXV, 7, 3'd5);
        drain();

        for (int i = 0; i < 250; i++) begin
            op = 3'($urandom % 8);
            a = rnd_val();
            b = rnd_val();
            if (op == 3'd4) b = ($urandom % 10 == 0) ? -longint'($urandom % 5 + 1) : longint'($urandom % 16);
            if ((op == 3'd3 || op == 3'd5) && $urandom % 8 == 0) b = 0;
            issue(a, b, op);
        end
        drain();

        bp = 1'b1;
        issue(3, 4, 3'd0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid_seen", longint'(bus.out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_result_hold", bus.result, 7);
            chk("bp_in_ready_low", longint'(bus.in_ready), 0);
            chk("bp_out_valid_hold", longint'(bus.out_valid), 1);
        end
        bp = 1'b0;
        drain();

        issue(-7, 2, 3'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", longint'(bus.out_valid), 0);
        chk("abort_in_ready", longint'(bus.in_ready), 1);
        q.delete();
        rst_n = 1'b1;
        issue(-40, 6, 3'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
